// File: rtl/apb_simple_master.sv
// rtl/apb_simple_master.sv - APB initiator turning one valid/ready request into one APB transfer
//
// Purpose:
//   Accepts a core-side request (valid/ready) and runs it as a single APB
//   transfer.
//   - SETUP phase: PSEL=1, PENABLE=0.
//   - ACCESS phase: PSEL=1, PENABLE=1, stretched by PREADY wait states.
//   - The result is returned as a one-cycle rsp_valid_o pulse carrying
//     PRDATA and PSLVERR.
//   - Every output is registered, except req_ready_o.
//   - Optional ACCESS timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
//
// Ports:
//   HCLK, HRESET       clock (posedge) and synchronous active-high reset
//   req_valid_i        request valid; must be held until req_ready_o
//   req_ready_o        request accepted when req_valid_i & req_ready_o
//   req_addr_i         request byte address
//   req_wdata_i        request write data
//   req_write_i        request direction (1 = write)
//   rsp_valid_o        one-cycle response pulse
//   rsp_rdata_o        response read data (0 for writes and timeouts)
//   rsp_err_o          PSLVERR seen, or timeout
//   rsp_timeout_o      transfer aborted by the ACCESS timeout
//   busy_o             a transfer is in SETUP or ACCESS
//   PADDR, PWDATA,     APB requester outputs
//   PWRITE, PSEL,
//   PENABLE
//   PRDATA, PREADY,    APB completer inputs
//   PSLVERR
module apb_simple_master #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]               req_wdata_i,
  input  logic                      req_write_i,
  output logic                      rsp_valid_o,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                    state_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]               pwdata_q;
  logic                      pwrite_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      rsp_valid_q;
  logic [31:0]               rsp_rdata_q;
  logic                      rsp_err_q;
  logic                      busy_q;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("apb_simple_master: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_MASTER_TIMEOUT_EN
  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             rsp_timeout_q;
  logic             tmo_hit;

  assign tmo_hit       = (tmo_cnt_q == CNT_LAST);
  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  // Ready depends only on state so the requester sees no combinational
  // path from its own valid.
  assign req_ready_o = (state_q == ST_IDLE) & ~HRESET;

  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PWRITE      = pwrite_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = busy_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      // An in-flight transfer is dropped here without a response.
      state_q       <= ST_IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // req_ready_o is 1 in IDLE outside reset, so valid alone accepts.
          if (req_valid_i) begin
            paddr_q   <= req_addr_i;
            pwdata_q  <= req_wdata_i;
            pwrite_q  <= req_write_i;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ST_ACCESS: begin
          if (PREADY) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? 32'h0 : PRDATA;
            rsp_err_q     <= PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
            state_q       <= ST_IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (tmo_hit) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
